// File: rtl/mem_access_checker_pkg.sv
// ============================================================================
// Module  : mem_chk_pkg
// Brief   : Cause/size codes and helpers shared by the data-memory checker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_chk_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE        = 3'd0,
    CAUSE_RD_MIS      = 3'd1,
    CAUSE_WR_MIS      = 3'd2,
    CAUSE_OOB         = 3'd3,
    CAUSE_RW_CONFLICT = 3'd4
  } cause_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } size_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } rec_state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] code);
    case (code)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] code, input logic [1:0] lsb);
    case (code)
      SZ_HALF: is_misaligned = lsb[0];
      SZ_WORD: is_misaligned = (lsb != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_checker_if.sv
// ============================================================================
// Module  : mem_chk_if
// Brief   : MEM-stage access bus plus exception-record handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_chk_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              acc_valid;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        wr_ctrl;
  logic [1:0]        rd_ctrl;
  logic              lui_bypass;
  logic              mem_kill;
  logic              exc_valid;
  logic [2:0]        exc_cause;
  logic [ADDR_W-1:0] exc_addr;
  logic              exc_overflow;
  logic              exc_ack;

  modport master (
    output acc_valid, addr, wr_ctrl, rd_ctrl, lui_bypass, exc_ack,
    input  mem_kill, exc_valid, exc_cause, exc_addr, exc_overflow
  );

  modport slave (
    input  acc_valid, addr, wr_ctrl, rd_ctrl, lui_bypass, exc_ack,
    output mem_kill, exc_valid, exc_cause, exc_addr, exc_overflow
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_checker_classify.sv
// ============================================================================
// Module  : mem_access_classify
// Brief   : Combinational fault classifier for one data-memory access.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_classify
  import mem_chk_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MEM_BYTES = 128
) (
  input  wire logic [ADDR_W-1:0] addr,
  input  wire logic [1:0]        wr_ctrl,
  input  wire logic [1:0]        rd_ctrl,
  input  wire logic              lui_bypass,
  input  wire logic              acc_valid,
  output logic                   fault_now,
  output cause_e                 cause
);

  // One extra bit so an access ending past the top of the address space cannot wrap.
  localparam logic [ADDR_W:0] c_one = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] c_lo  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] c_hi  = {1'b0, BASE_ADDR} + (ADDR_W+1)'(MEM_BYTES) - c_one;

  logic            w_rd_act;
  logic            w_wr_act;
  logic            w_check;
  logic [2:0]      w_size;
  logic [ADDR_W:0] w_addr_ext;
  logic [ADDR_W:0] w_end_addr;
  logic            w_oob;

  always_comb begin
    w_rd_act   = (rd_ctrl != SZ_NONE);
    w_wr_act   = (wr_ctrl != SZ_NONE);
    w_check    = acc_valid && !lui_bypass && (w_rd_act || w_wr_act);
    w_size     = w_rd_act ? size_bytes(rd_ctrl) : size_bytes(wr_ctrl);
    w_addr_ext = {1'b0, addr};
    w_end_addr = w_addr_ext + {{(ADDR_W-2){1'b0}}, w_size} - c_one;
    w_oob      = (w_addr_ext < c_lo) || (w_end_addr > c_hi);

    cause = CAUSE_NONE;
    if (w_check) begin
      if (w_rd_act && w_wr_act)
        cause = CAUSE_RW_CONFLICT;
      else if (w_rd_act && is_misaligned(rd_ctrl, addr[1:0]))
        cause = CAUSE_RD_MIS;
      else if (w_wr_act && is_misaligned(wr_ctrl, addr[1:0]))
        cause = CAUSE_WR_MIS;
      else if (w_oob)
        cause = CAUSE_OOB;
    end
    fault_now = (cause != CAUSE_NONE);
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_checker.sv
// ============================================================================
// Module  : mem_access_checker
// Brief   : MEM-stage access checker: same-cycle kill, first-fault record, counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_checker
  import mem_chk_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MEM_BYTES = 128,
  parameter int unsigned       CNT_W     = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mem_chk_if.slave         bus,
  input  wire logic        cnt_clr,
  output logic [CNT_W-1:0] cnt_rd_mis,
  output logic [CNT_W-1:0] cnt_wr_mis,
  output logic [CNT_W-1:0] cnt_oob
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              w_fault;
  cause_e            w_cause;
  rec_state_e        r_state;
  logic              r_valid;
  cause_e            r_cause;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cnt_rd;
  logic [CNT_W-1:0]  r_cnt_wr;
  logic [CNT_W-1:0]  r_cnt_oob;

  mem_access_classify #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .MEM_BYTES (MEM_BYTES)
  ) u_classify (
    .addr       (bus.addr),
    .wr_ctrl    (bus.wr_ctrl),
    .rd_ctrl    (bus.rd_ctrl),
    .lui_bypass (bus.lui_bypass),
    .acc_valid  (bus.acc_valid),
    .fault_now  (w_fault),
    .cause      (w_cause)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_cause <= CAUSE_NONE;
      r_addr  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fault) begin
            r_state <= ST_HELD;
            r_valid <= 1'b1;
            r_cause <= w_cause;
            r_addr  <= bus.addr;
            r_ovf   <= 1'b0;
          end
        end
        ST_HELD: begin
          if (w_fault) begin
            // An ack in the same cycle frees the record for the new fault.
            if (bus.exc_ack) begin
              r_cause <= w_cause;
              r_addr  <= bus.addr;
              r_ovf   <= 1'b0;
            end else begin
              r_ovf   <= 1'b1;
            end
          end else if (bus.exc_ack) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_cause <= CAUSE_NONE;
            r_ovf   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_rd  <= '0;
      r_cnt_wr  <= '0;
      r_cnt_oob <= '0;
    end else if (cnt_clr) begin
      r_cnt_rd  <= '0;
      r_cnt_wr  <= '0;
      r_cnt_oob <= '0;
    end else begin
      if (w_cause == CAUSE_RD_MIS && r_cnt_rd != c_cnt_max)
        r_cnt_rd <= r_cnt_rd + c_cnt_one;
      if (w_cause == CAUSE_WR_MIS && r_cnt_wr != c_cnt_max)
        r_cnt_wr <= r_cnt_wr + c_cnt_one;
      if (w_cause == CAUSE_OOB && r_cnt_oob != c_cnt_max)
        r_cnt_oob <= r_cnt_oob + c_cnt_one;
    end
  end

  assign bus.mem_kill     = w_fault;
  assign bus.exc_valid    = r_valid;
  assign bus.exc_cause    = r_cause;
  assign bus.exc_addr     = r_addr;
  assign bus.exc_overflow = r_ovf;
  assign cnt_rd_mis       = r_cnt_rd;
  assign cnt_wr_mis       = r_cnt_wr;
  assign cnt_oob          = r_cnt_oob;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_checker.sv
// ============================================================================
// Module  : tb_mem_access_checker
// Brief   : Scoreboard bench for mem_access_checker against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_checker;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int          MEM    = 128;
  localparam int          CNT_W  = 2;
  localparam int          CMAX   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_rd_mis;
  logic [CNT_W-1:0] cnt_wr_mis;
  logic [CNT_W-1:0] cnt_oob;

  mem_chk_if #(.ADDR_W(ADDR_W)) bus();

  mem_access_checker #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE),
    .MEM_BYTES (MEM),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cnt_clr    (cnt_clr),
    .cnt_rd_mis (cnt_rd_mis),
    .cnt_wr_mis (cnt_wr_mis),
    .cnt_oob    (cnt_oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          kill;
    bit          valid;
    int          cause;
    logic [31:0] addr;
    bit          ovf;
    int          crd;
    int          cwr;
    int          coob;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bit          m_valid;
  int          m_cause;
  logic [31:0] m_addr;
  bit          m_ovf;
  int          m_crd, m_cwr, m_coob;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cause of an access derived directly from the size/alignment/window rules.
  function automatic int model_cause(bit v, logic [31:0] a, logic [1:0] wr, logic [1:0] rd, bit lui);
    longint unsigned sz, la;
    if (!v || lui || (wr == 2'd3 && rd == 2'd3)) return 0;
    if (wr != 2'd3 && rd != 2'd3) return 4;
    sz = (rd != 2'd3) ? (64'd1 << rd) : (64'd1 << wr);
    la = {32'd0, a};
    if (la % sz != 0) return (rd != 2'd3) ? 1 : 2;
    if (la < {32'd0, BASE} || la + sz > {32'd0, BASE} + MEM) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_cause = 0; m_addr = '0; m_ovf = 0;
    m_crd = 0; m_cwr = 0; m_coob = 0;
  endtask

  task automatic idle();
    bus.acc_valid  = 1'b0;
    bus.addr       = '0;
    bus.wr_ctrl    = 2'd3;
    bus.rd_ctrl    = 2'd3;
    bus.lui_bypass = 1'b0;
    bus.exc_ack    = 1'b0;
    cnt_clr        = 1'b0;
  endtask

  task automatic step(bit v, logic [31:0] a, logic [1:0] wr, logic [1:0] rd, bit lui, bit ack, bit clr);
    exp_t e;
    int   c;
    @(negedge clk);
    bus.acc_valid  = v;
    bus.addr       = a;
    bus.wr_ctrl    = wr;
    bus.rd_ctrl    = rd;
    bus.lui_bypass = lui;
    bus.exc_ack    = ack;
    cnt_clr        = clr;
    c = model_cause(v, a, wr, rd, lui);
    if (c != 0) begin
      if (!m_valid || ack) begin
        m_valid = 1; m_cause = c; m_addr = a; m_ovf = 0;
      end else begin
        m_ovf = 1;
      end
    end else if (m_valid && ack) begin
      m_valid = 0; m_cause = 0; m_ovf = 0;
    end
    if (clr) begin
      m_crd = 0; m_cwr = 0; m_coob = 0;
    end else begin
      if (c == 1 && m_crd  < CMAX) m_crd++;
      if (c == 2 && m_cwr  < CMAX) m_cwr++;
      if (c == 3 && m_coob < CMAX) m_coob++;
    end
    e.kill = (c != 0); e.valid = m_valid; e.cause = m_cause; e.addr = m_addr;
    e.ovf = m_ovf; e.crd = m_crd; e.cwr = m_cwr; e.coob = m_coob;
    q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  64'(bus.exc_valid),    64'd0);
    check({tag, "_cause"},  64'(bus.exc_cause),    64'd0);
    check({tag, "_addr"},   64'(bus.exc_addr),     64'd0);
    check({tag, "_ovf"},    64'(bus.exc_overflow), 64'd0);
    check({tag, "_cnt_rd"}, 64'(cnt_rd_mis),       64'd0);
    check({tag, "_cnt_wr"}, 64'(cnt_wr_mis),       64'd0);
    check({tag, "_cnt_oob"},64'(cnt_oob),          64'd0);
  endtask

  // Monitor: mem_kill sampled before the edge takes effect, state 1 time unit after.
  initial begin : monitor
    exp_t e;
    bit   k;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        k = bus.mem_kill;
        #1;
        check("mem_kill",     64'(k),                e.kill);
        check("exc_valid",    64'(bus.exc_valid),    64'(e.valid));
        check("exc_cause",    64'(bus.exc_cause),    64'(e.cause));
        check("exc_addr",     64'(bus.exc_addr),     64'(e.addr));
        check("exc_overflow", 64'(bus.exc_overflow), 64'(e.ovf));
        check("cnt_rd_mis",   64'(cnt_rd_mis),       64'(e.crd));
        check("cnt_wr_mis",   64'(cnt_wr_mis),       64'(e.cwr));
        check("cnt_oob",      64'(cnt_oob),          64'(e.coob));
      end
    end
  end

  initial begin : stimulus
    logic [31:0] a;
    int          guard;
    idle();
    model_reset();
    #3;
    check_all_zero("reset");
    check("reset_kill", 64'(bus.mem_kill), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 32'h06, 2'd2, 2'd3, 0, 0, 0);        // store word misaligned
    step(1, 32'h7F, 2'd3, 2'd1, 0, 0, 0);        // second fault while held
    step(1, 32'h7F, 2'd3, 2'd1, 0, 1, 0);        // ack + new fault
    step(1, 32'h7E, 2'd3, 2'd1, 0, 1, 0);        // aligned half at window end, ack
    step(1, 32'h80, 2'd3, 2'd2, 0, 0, 0);        // word just past window
    step(1, 32'h10, 2'd2, 2'd2, 0, 1, 0);        // read+write conflict
    step(1, 32'h10, 2'd2, 2'd2, 1, 1, 0);        // same access bypassed
    step(1, 32'hFFFF_FFFF, 2'd3, 2'd0, 0, 0, 0); // top of address space
    step(1, 32'hFFFF_FFFC, 2'd2, 2'd3, 0, 0, 0);
    repeat (4) step(1, 32'h200, 2'd3, 2'd0, 0, 0, 0);
    step(1, 32'h200, 2'd3, 2'd0, 0, 1, 1);       // clear beats increment
    step(0, 32'h0, 2'd3, 2'd3, 0, 1, 0);
    step(0, 32'h0, 2'd3, 2'd3, 0, 1, 0);         // ack while idle is ignored
    step(1, 32'h40, 2'd3, 2'd3, 0, 0, 0);        // no ctrl: no check

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'hFFFF_FFFF - $urandom_range(0, 7);
        default: a = $urandom_range(0, MEM + 15);
      endcase
      step($urandom_range(0, 9) < 8, a, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset while a record is held.
    step(1, 32'h06, 2'd2, 2'd3, 0, 0, 0);
    @(posedge clk);
    #3;
    idle();
    check("pre_reset_valid", 64'(bus.exc_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 60; i++) begin
      step(1, $urandom_range(0, MEM + 7), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           0, $urandom_range(0, 3) == 0, 0);
    end

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #3;
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
